// File: rtl/wb_grf_pkg.sv
// Shared definitions for the write-back stage register file.
// Write-data select encodings and the hard-wired zero register index.
package wb_grf_pkg;

  typedef enum logic [1:0] {
    WDSEL_ALU  = 2'b00,
    WDSEL_DM   = 2'b01,
    WDSEL_PC8  = 2'b10,
    WDSEL_NONE = 2'b11
  } wdsel_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_grf_array.sv
// General register storage: one synchronous write port, two combinational read ports.
// Register 0 is hard-wired to zero and has no storage.
module grf_array
  import wb_grf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [NREG];

  assign regs_reg[REG_ZERO] = '0;

  // Per-register flops so the whole file clears in a single reset edge.
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_reg[gi] <= '0;
        end else if (w_en && (w_addr == ADDR_W'(gi))) begin
          regs_reg[gi] <= w_data;
        end
      end
    end
  endgenerate

  assign ra_data = regs_reg[ra_addr];
  assign rb_data = regs_reg[rb_addr];

endmodule

// File: rtl/wb_grf.sv
// Write-back stage register file: write-data select, retire counter, commit observation.
// Define WB_GRF_BYPASS_EN to forward same-cycle write data to matching read ports.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_pc4,
  input  logic [DATA_W-1:0] wb_aluout,
  input  logic [DATA_W-1:0] wb_dmdata,
  input  logic [ADDR_W-1:0] wb_wreg,
  input  logic [1:0]        wb_wdsel,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_we_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [31:0]       retire_cnt
);

  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;
  logic [31:0]       retire_cnt_reg;

  assign we = wb_valid && (wb_wreg != ADDR_W'(REG_ZERO)) && (wb_wdsel != WDSEL_NONE);

  always_comb begin
    wdata = wb_aluout;
    case (wb_wdsel)
      WDSEL_DM:  wdata = wb_dmdata;
      WDSEL_PC8: wdata = wb_pc4 + DATA_W'(4);
      default:   wdata = wb_aluout;
    endcase
  end

  grf_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .w_en    (we),
    .w_addr  (wb_wreg),
    .w_data  (wdata),
    .ra_addr (rs_addr),
    .rb_addr (rt_addr),
    .ra_data (rs_stored),
    .rb_data (rt_stored)
  );

  // Counts every valid instruction, including ones that do not write.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_reg <= '0;
    end else if (wb_valid) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

`ifdef WB_GRF_BYPASS_EN
  // No forwarding while in reset: reads then show the stored array only.
  assign rs_data = (we && !reset && (rs_addr == wb_wreg)) ? wdata : rs_stored;
  assign rt_data = (we && !reset && (rt_addr == wb_wreg)) ? wdata : rt_stored;
`else
  assign rs_data = rs_stored;
  assign rt_data = rt_stored;
`endif

  assign wb_we_o    = we;
  assign wb_wdata_o = wdata;
  assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed scenarios plus randomized traffic
// compared every cycle against a behavioural register-file model.
module tb_wb_grf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;
`ifdef WB_GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_pc4, wb_aluout, wb_dmdata;
  logic [ADDR_W-1:0] wb_wreg;
  logic [1:0]        wb_wdsel;
  logic [ADDR_W-1:0] rs_addr, rt_addr;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              wb_we_o;
  logic [DATA_W-1:0] wb_wdata_o;
  logic [31:0]       retire_cnt;

  wb_grf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_pc4     (wb_pc4),
    .wb_aluout  (wb_aluout),
    .wb_dmdata  (wb_dmdata),
    .wb_wreg    (wb_wreg),
    .wb_wdsel   (wb_wdsel),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wb_we_o    (wb_we_o),
    .wb_wdata_o (wb_wdata_o),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  bit          chk_en = 1'b0;

  logic [DATA_W-1:0] m_regs [NREG];
  logic [31:0]       m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel_data(input logic [1:0] sel, input logic [31:0] pc4,
                                           input logic [31:0] alu, input logic [31:0] dm);
    if (sel == 2'd1) return dm;
    if (sel == 2'd2) return pc4 + 32'd4;
    return alu;
  endfunction

  // Reference model: commits architectural state at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_cnt = '0;
    end else begin
      if (wb_valid) m_cnt = m_cnt + 32'd1;
      if (wb_valid && wb_wdsel != 2'b11 && wb_wreg != '0)
        m_regs[wb_wreg] = sel_data(wb_wdsel, wb_pc4, wb_aluout, wb_dmdata);
    end
  end

  // Compare process: checks combinational outputs mid-cycle.
  always @(negedge clk) begin : cmp
    logic              m_we;
    logic [DATA_W-1:0] wd, ers, ert;
    if (chk_en) begin
      m_we = wb_valid && wb_wdsel != 2'b11 && wb_wreg != '0;
      wd   = sel_data(wb_wdsel, wb_pc4, wb_aluout, wb_dmdata);
      ers  = m_regs[rs_addr];
      ert  = m_regs[rt_addr];
      if (BYP && m_we && !reset && rs_addr == wb_wreg) ers = wd;
      if (BYP && m_we && !reset && rt_addr == wb_wreg) ert = wd;
      check("rs_data", rs_data, ers);
      check("rt_data", rt_data, ert);
      check("wb_we_o", {31'd0, wb_we_o}, {31'd0, m_we});
      if (wb_wdsel != 2'b11) check("wb_wdata_o", wb_wdata_o, wd);
      check("retire_cnt", retire_cnt, m_cnt);
    end
  end

  task automatic set_in(input logic rst, input logic v, input logic [1:0] sel,
                        input logic [ADDR_W-1:0] wr, input logic [31:0] pc4,
                        input logic [31:0] alu, input logic [31:0] dm,
                        input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    reset = rst; wb_valid = v; wb_wdsel = sel; wb_wreg = wr;
    wb_pc4 = pc4; wb_aluout = alu; wb_dmdata = dm; rs_addr = rs; rt_addr = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] cnt_before;

  initial begin
    set_in(1'b1, 1'b0, 2'b11, '0, '0, '0, '0, '0, '0);
    step();
    step();
    chk_en = 1'b1;
    set_in(1'b0, 1'b0, 2'b11, '0, '0, '0, '0, 5'd8, 5'd1);
    #1;
    check("reset_cnt", retire_cnt, 32'd0);
    check("reset_rs8", rs_data, 32'd0);

    // ALU write to r8, read back next cycle.
    set_in(1'b0, 1'b1, 2'b00, 5'd8, '0, 32'h1234, '0, 5'd8, 5'd8);
    step();
    check("alu_r8", rs_data, 32'h0000_1234);
    check("alu_cnt", retire_cnt, 32'd1);

    // PC+8 path including wrap.
    set_in(1'b0, 1'b1, 2'b10, 5'd31, 32'h0000_3004, '0, '0, 5'd31, 5'd0);
    step();
    check("pc8_r31", rs_data, 32'h0000_3008);
    set_in(1'b0, 1'b1, 2'b10, 5'd31, 32'hFFFF_FFFC, '0, '0, 5'd31, 5'd0);
    #1;
    check("pc8_wrap_wdata", wb_wdata_o, 32'h0);
    step();
    check("pc8_wrap_r31", rs_data, 32'h0);

    // Write to r0 is dropped but still retires.
    cnt_before = retire_cnt;
    set_in(1'b0, 1'b1, 2'b00, 5'd0, '0, 32'hDEAD, '0, 5'd0, 5'd0);
    #1;
    check("r0_we", {31'd0, wb_we_o}, 32'd0);
    step();
    check("r0_read", rs_data, 32'h0);
    check("r0_cnt", retire_cnt, cnt_before + 32'd1);

    // Bubble and no-write instruction.
    set_in(1'b0, 1'b1, 2'b01, 5'd5, '0, '0, 32'h77, 5'd5, 5'd5);
    step();
    cnt_before = retire_cnt;
    set_in(1'b0, 1'b0, 2'b01, 5'd5, '0, '0, 32'h5555, 5'd5, 5'd5);
    step();
    check("bubble_cnt", retire_cnt, cnt_before);
    check("bubble_r5", rs_data, 32'h77);
    set_in(1'b0, 1'b1, 2'b11, 5'd5, '0, 32'h6666, 32'h6666, 5'd5, 5'd5);
    step();
    check("nowrite_cnt", retire_cnt, cnt_before + 32'd1);
    check("nowrite_r5", rs_data, 32'h77);

    // Same-cycle read of the register being written.
    set_in(1'b0, 1'b1, 2'b00, 5'd9, '0, 32'hAAAA, '0, 5'd9, 5'd9);
    #2;
    check("hazard_rs", rs_data, BYP ? 32'hAAAA : 32'h0);
    check("hazard_rt", rt_data, BYP ? 32'hAAAA : 32'h0);
    step();
    set_in(1'b0, 1'b0, 2'b11, 5'd0, '0, '0, '0, 5'd9, 5'd9);
    #1;
    check("hazard_next_rs", rs_data, 32'hAAAA);
    check("hazard_next_rt", rt_data, 32'hAAAA);

    // Counter wrap from a preloaded value.
    force dut.retire_cnt_reg = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_reg;
    set_in(1'b0, 1'b1, 2'b11, 5'd0, '0, '0, '0, 5'd3, 5'd3);
    step();
    check("cnt_wrap", retire_cnt, 32'd0);

    // Reset beats a simultaneous write and count.
    set_in(1'b0, 1'b1, 2'b00, 5'd3, '0, 32'h3333, '0, 5'd3, 5'd3);
    step();
    check("pre_rst_r3", rs_data, 32'h3333);
    set_in(1'b1, 1'b1, 2'b00, 5'd3, '0, 32'h4444, '0, 5'd3, 5'd3);
    step();
    set_in(1'b0, 1'b0, 2'b11, 5'd0, '0, '0, '0, 5'd3, 5'd3);
    #1;
    check("rst_r3", rs_data, 32'h0);
    check("rst_cnt", retire_cnt, 32'd0);

    // Randomized traffic; compare process checks every cycle.
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, NREG - 1)),
             $urandom(), $urandom(), $urandom(),
             ADDR_W'($urandom_range(0, NREG - 1)), ADDR_W'($urandom_range(0, NREG - 1)));
      if ($urandom_range(0, 4) == 0) rt_addr = wb_wreg;
      if ($urandom_range(0, 4) == 0) rs_addr = rt_addr;
      if ($urandom_range(0, 9) == 0) wb_pc4 = 32'hFFFF_FFFC;
      step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register and data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width (2**ADDR_W registers).
REQ-003 The block SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port wb_valid, input, 1, meaning a real instruction occupies WB (0 = bubble).
REQ-006 The block SHALL have ports wb_pc4, wb_aluout and wb_dmdata, input, DATA_W each, meaning the WB-stage PC+4, ALU result and memory load data.
REQ-007 The block SHALL have port wb_wreg, input, ADDR_W, meaning the destination register.
REQ-008 The block SHALL have port wb_wdsel, input, 2, meaning the write-data select: 00 ALU, 01 DM, 10 PC+8, 11 no write.
REQ-009 The block SHALL have ports rs_addr and rt_addr, input, ADDR_W each, meaning the decode-stage read addresses.
REQ-010 The block SHALL have ports rs_data and rt_data, output, DATA_W each, meaning the read data.
REQ-011 The block SHALL have ports wb_we_o (output, 1) and wb_wdata_o (output, DATA_W), meaning the commit-observation write enable and write data.
REQ-012 The block SHALL have port retire_cnt, output, 32, meaning the count of retired (valid) instructions.

Function
REQ-013 The write enable SHALL be defined as we = wb_valid AND wb_wreg != 0 AND wb_wdsel != 11.
REQ-014 The write data SHALL be wb_aluout (00), wb_dmdata (01) or wb_pc4 + 4 modulo 2**DATA_W (10); wb_pc4 = 0xFFFFFFFC yields 0x00000000.
REQ-015 When we = 1, the selected data SHALL be written to register wb_wreg at the rising edge, with the stored value visible in the following cycle.
REQ-016 Register 0 SHALL always read 0 and SHALL never be written.
REQ-017 Reads SHALL be combinational from the stored array, with zero latency.
REQ-018 wb_we_o and wb_wdata_o SHALL be combinational copies of we and the selected write data.
REQ-019 retire_cnt SHALL increment by 1 on each rising edge with wb_valid = 1, independent of we, and SHALL wrap 0xFFFFFFFF to 0.
REQ-020 If rs_addr equals rt_addr, both ports SHALL return identical data.

Reset
REQ-021 Reset SHALL clear all registers and retire_cnt to 0 on the rising edge where reset = 1.
REQ-022 Reset SHALL take priority over a simultaneous write and count, so nothing is written or counted in that cycle.
REQ-023 During reset, rs_data and rt_data SHALL reflect the stored (possibly pre-clear) array, and are 0 from the cycle after the reset edge.

Configuration
REQ-024 The macro WB_GRF_BYPASS_EN SHALL control internal write-through bypass.
REQ-025 With WB_GRF_BYPASS_EN defined, a read port whose address equals wb_wreg while we = 1 SHALL return the write data in the same cycle.
REQ-026 Without WB_GRF_BYPASS_EN, read ports SHALL return the old stored value in that cycle, and the external forwarding unit resolves the hazard.

Structure
REQ-027 The shared package SHALL hold the wdsel encodings (WDSEL_ALU, WDSEL_DM, WDSEL_PC8, WDSEL_NONE) and the constant REG_ZERO.
REQ-028 The block SHALL contain exactly one sub-module, grf_array, holding the storage with one write port and two read ports; write-data mux, bypass and counter stay in wb_grf.

Verification
REQ-029 Test: reset, then wb_valid=1, wdsel=00, wreg=8, aluout=0x1234, rs_addr=8 -> next cycle rs_data=0x1234, retire_cnt=1.
REQ-030 Test: wdsel=10, wb_pc4=0x00003004, wreg=31 -> reg31=0x00003008; with wb_pc4=0xFFFFFFFC -> reg31=0.
REQ-031 Test: wreg=0, aluout=0xDEAD, wb_valid=1 -> rs_addr=0 reads 0, wb_we_o=0, retire_cnt still increments.
REQ-032 Test: wb_valid=0 with wreg=5 and wdsel=01, then wb_valid=1 with wdsel=11 -> reg5 unchanged, retire_cnt +0 then +1.
REQ-033 Test: write reg9=0xAAAA while rs_addr=rt_addr=9 in the same cycle -> with the macro both ports read 0xAAAA that cycle; without it they read the old value, then 0xAAAA the next cycle.
REQ-034 Test: preload retire_cnt to 0xFFFFFFFF then one valid instruction -> 0; reset asserted together with a write to reg3 -> reg3=0, retire_cnt=0.
